// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle and control states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_XOR = 4'b0010,
      OP_NOT = 4'b0011,
      OP_SRL = 4'b0100,
      OP_SLL = 4'b0101,
      OP_SRA = 4'b0110,
      OP_ROR = 4'b0111,
      OP_ADD = 4'b1000,
      OP_SUB = 4'b1001,
      OP_ADC = 4'b1010,
      OP_SBC = 4'b1011,
      OP_MUL = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } alu_flags_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } estado_e;

   // A zero result is held after reset, so Z starts set.
   localparam alu_flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b1, v: 1'b0, c: 1'b0};

endpackage

// File: rtl/multiplicador_secuencial.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
module multiplicador_secuencial #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] producto
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [2*N-1:0] mcand;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_next;
   logic [N-1:0]   mplr;
   logic [CNT_W-1:0] cnt;

   // Accumulator after the step taken this cycle; on the last step this is the
   // full product, so the consumer can capture it on the same edge.
   always_comb begin
      acc_next = acc + (mplr[0] ? mcand : '0);
   end

   assign done     = busy && (cnt == LAST);
   assign producto = acc_next;

   // Operand latch on start, then one shift-add step per cycle for N cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         mcand <= {{N{1'b0}}, a};
         mplr  <= b;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc   <= acc_next;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         if (cnt == LAST) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/unidad_logico_aritmetica_secuencial.sv
// Registered ALU with valid/ready handshakes, stored carry and iterative MUL.
//
// state | meaning
// IDLE  | ready for an operation; non-MUL ops complete on accept
// MUL   | multiplier stepping, one partial product per cycle
// DONE  | result and flags held until the consumer takes them
module unidad_logico_aritmetica_secuencial
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] operador1,
   input  logic [N-1:0] operador2,
   input  logic [3:0]   ALUControl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] resultadoFinal,
   output logic         flagNegativo,
   output logic         flagCero,
   output logic         flagOverflow,
   output logic         flagCarry,
   output logic         opInvalido
);

   localparam int SHAMT_W = $clog2(N) + 1;
   localparam logic [SHAMT_W-1:0] N_SH = SHAMT_W'(N);
   localparam logic [N-1:0]       N_OP = N[N-1:0];

   estado_e state, state_next;

   logic [N-1:0]   res_q;
   alu_flags_t     flags_q;
   logic           inv_q;

   logic           accept;
   logic           is_mul;
   logic           mul_busy;
   logic           mul_done;
   logic [2*N-1:0] producto;

   logic [SHAMT_W-1:0] amt;
   logic [SHAMT_W-1:0] rot;
   logic [N-1:0]       b_op;
   logic               cin;
   logic [N:0]         sum;
   logic               arith_v;
   logic [N-1:0]       alu_res;
   logic               alu_v;
   logic               alu_c;
   logic               alu_inv;

   assign accept = in_valid && in_ready;
   assign is_mul = (ALUControl == OP_MUL);

   multiplicador_secuencial #(.N(N)) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept && is_mul),
      .a        (operador1),
      .b        (operador2),
      .busy     (mul_busy),
      .done     (mul_done),
      .producto (producto)
   );

   // Shared adder: opcode bit 0 selects subtraction (invert B), bit 1 takes
   // the carry-in from the stored carry flag instead of the fixed value.
   always_comb begin
      b_op    = ALUControl[0] ? ~operador2 : operador2;
      cin     = ALUControl[1] ? flags_q.c : ALUControl[0];
      sum     = {1'b0, operador1} + {1'b0, b_op} + {{N{1'b0}}, cin};
      arith_v = (operador1[N-1] == b_op[N-1]) && (sum[N-1] != operador1[N-1]);
      amt     = (operador2 > N_OP) ? N_SH : operador2[SHAMT_W-1:0];
      rot     = SHAMT_W'(operador2 % N_OP);
   end

   // Single-cycle result and carry/overflow for every non-MUL opcode.
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      alu_inv = 1'b0;
      case (ALUControl)
         OP_AND: alu_res = operador1 & operador2;
         OP_OR:  alu_res = operador1 | operador2;
         OP_XOR: alu_res = operador1 ^ operador2;
         OP_NOT: alu_res = ~operador1;
         OP_SRL: alu_res = operador1 >> amt;
         OP_SLL: alu_res = operador1 << amt;
         OP_SRA: alu_res = $unsigned($signed(operador1) >>> amt);
         OP_ROR: alu_res = (operador1 >> rot) | (operador1 << (N_SH - rot));
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            alu_res = sum[N-1:0];
            alu_c   = sum[N];
            alu_v   = arith_v;
         end
         OP_MUL: alu_res = '0;
         default: alu_inv = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = is_mul ? MUL : DONE;
         MUL:  if (mul_done) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs.
   always_comb begin
      in_ready  = (state == IDLE) && !mul_busy;
      out_valid = (state == DONE);
   end

   // Result/flag register; also the stored carry read back by ADC/SBC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         flags_q <= FLAGS_RESET;
         inv_q   <= 1'b0;
      end else if (accept && !is_mul) begin
         res_q     <= alu_res;
         flags_q.n <= alu_res[N-1];
         flags_q.z <= (alu_res == '0);
         flags_q.v <= alu_v;
         flags_q.c <= alu_c;
         inv_q     <= alu_inv;
      end else if (state == MUL && mul_done) begin
         res_q     <= producto[N-1:0];
         flags_q.n <= producto[N-1];
         flags_q.z <= (producto[N-1:0] == '0);
         flags_q.v <= |producto[2*N-1:N];
         flags_q.c <= 1'b0;
         inv_q     <= 1'b0;
      end
   end

   assign resultadoFinal = res_q;
   assign flagNegativo   = flags_q.n;
   assign flagCero       = flags_q.z;
   assign flagOverflow   = flags_q.v;
   assign flagCarry      = flags_q.c;
   assign opInvalido     = inv_q;

endmodule
